// File: rtl/tmp_code_accum_if.sv
// rtl/tmp_code_accum_if.sv - result handshake between the decimator and the readout logic
// Purpose: bundles the temperature code and its valid/ready handshake.
// Signals:
//   code        temperature code (number of cmp=1 decisions in a window)
//   code_valid  code holds an unconsumed result
//   code_ready  consumer accepts code when code_valid & code_ready at a rising edge
// Modports: master = decimator (drives code/code_valid), slave = readout logic.
interface tmp_code_accum_if #(
  parameter int CODE_W = 7
) ();
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;

  modport master (output code, output code_valid, input code_ready);
  modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/tmp_code_accum.sv
// rtl/tmp_code_accum.sv - incremental sigma-delta count decimator for the temperature sensor
// Purpose: after start, drops DISCARD comparator strobes, then counts cmp=1 decisions over
//   2**OSR_LOG2 strobes and publishes the count as a temperature code.
// Ports:
//   clk, reset_n     clock (rising edge) and asynchronous active-low reset
//   start / stop     begin a conversion from IDLE / abort back to IDLE
//   cont             on completion go straight back to ACCUM (no discard)
//   cmp, cmp_strb    comparator decision and its 1-cycle valid strobe
//   code_if          master side of the code/code_valid/code_ready handshake
//   busy             registered, high whenever not IDLE
//   overrun          sticky: an unconsumed result was overwritten
//   timeout_err      sticky: strobe gap reached TIMEOUT
module tmp_code_accum #(
  parameter int OSR_LOG2 = 6,
  parameter int DISCARD  = 4,
  parameter int TIMEOUT  = 255,
  parameter int CODE_W   = OSR_LOG2 + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cont,
  input  logic                 cmp,
  input  logic                 cmp_strb,
  tmp_code_accum_if.master     code_if,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int DISC_W = (DISCARD > 1) ? $clog2(DISCARD) : 1;
  localparam int GAP_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [OSR_LOG2-1:0] CNT_LAST  = OSR_LOG2'((1 << OSR_LOG2) - 1);
  localparam logic [OSR_LOG2-1:0] CNT_ONE   = OSR_LOG2'(1);
  localparam logic [DISC_W-1:0]   DISC_LAST = DISC_W'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam logic [DISC_W-1:0]   DISC_ONE  = DISC_W'(1);
  // The gap counter fires on the cycle it would step from TIMEOUT-1 to TIMEOUT.
  localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GAP_W-1:0]    GAP_ONE   = GAP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM} state_t;

  state_t              r_state;
  logic [CODE_W-1:0]   r_acc;
  logic [OSR_LOG2-1:0] r_cnt;
  logic [DISC_W-1:0]   r_disc;
  logic [GAP_W-1:0]    r_gap;
  logic [CODE_W-1:0]   r_code;
  logic                r_valid;
  logic                r_busy;
  logic                r_overrun;
  logic                r_timeout;

  logic [CODE_W-1:0]   w_cmp_ext;
  logic [CODE_W-1:0]   w_acc_next;

  assign w_cmp_ext  = {{(CODE_W-1){1'b0}}, cmp};
  // acc holds at most N-1 before the last strobe, so acc+cmp tops out at N without wrapping.
  assign w_acc_next = r_acc + w_cmp_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_disc    <= '0;
      r_gap     <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      // Acceptance applies in every state; a completion below overrides it on the same edge.
      if (r_valid && code_if.code_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state   <= (DISCARD > 0) ? S_SETTLE : S_ACCUM;
            r_busy    <= 1'b1;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_disc    <= '0;
            r_gap     <= '0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
          end
        end

        S_SETTLE, S_ACCUM: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_disc  <= '0;
          end else if (cmp_strb) begin
            r_gap <= '0;
            if (r_state == S_SETTLE) begin
              if (r_disc == DISC_LAST) begin
                r_state <= S_ACCUM;
                r_disc  <= '0;
              end else begin
                r_disc <= r_disc + DISC_ONE;
              end
            end else if (r_cnt == CNT_LAST) begin
              r_code  <= w_acc_next;
              r_valid <= 1'b1;
              if (r_valid && !code_if.code_ready) begin
                r_overrun <= 1'b1;
              end
              r_acc <= '0;
              r_cnt <= '0;
              if (!cont) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= r_cnt + CNT_ONE;
            end
          end else if (r_gap == GAP_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_disc    <= '0;
          end else begin
            r_gap <= r_gap + GAP_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign code_if.code       = r_code;
  assign code_if.code_valid = r_valid;
  assign busy               = r_busy;
  assign overrun            = r_overrun;
  assign timeout_err        = r_timeout;

endmodule

// File: tb/tb_tmp_code_accum.sv
// tb/tb_tmp_code_accum.sv - self-checking bench for tmp_code_accum
module tb_tmp_code_accum;

  logic clk = 1'b0;
  logic reset_n;
  logic start, stop, cont, cmp, cmp_strb;
  logic busy, overrun, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  tmp_code_accum_if #(.CODE_W(7)) u_if ();

  tmp_code_accum #(
    .OSR_LOG2 (6),
    .DISCARD  (4),
    .TIMEOUT  (255),
    .CODE_W   (7)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .cont        (cont),
    .cmp         (cmp),
    .cmp_strb    (cmp_strb),
    .code_if     (u_if),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;       // 0 all zeros, 1 all ones, 2 alternating 1/0, 3 first k ones
    int k;
    int exp_code;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int k, input int j);
    case (pat)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (j % 2) == 0;
      default: return j < k;
    endcase
  endfunction

  task automatic strobes(input int pat, input int k, input int n);
    for (int j = 0; j < n; j++) begin
      cmp      = pat_bit(pat, k, j);
      cmp_strb = 1'b1;
      tick();
    end
    cmp_strb = 1'b0;
    cmp      = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Discard strobes carry cmp=1 so any leak into the count shows up.
  task automatic discard4();
    strobes(1, 0, 4);
  endtask

  task automatic accept();
    u_if.code_ready = 1'b1;
    tick();
    u_if.code_ready = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{pat: 2, k: 0,  exp_code: 32};
    vecs[1] = '{pat: 1, k: 0,  exp_code: 64};
    vecs[2] = '{pat: 0, k: 0,  exp_code: 0};
    vecs[3] = '{pat: 3, k: 5,  exp_code: 5};
    vecs[4] = '{pat: 3, k: 63, exp_code: 63};

    reset_n = 1'b0;
    start = 1'b0; stop = 1'b0; cont = 1'b0; cmp = 1'b0; cmp_strb = 1'b0;
    u_if.code_ready = 1'b0;
    tick(); tick();
    check("rst_code", int'(u_if.code), 0);
    check("rst_valid", int'(u_if.code_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_timeout", int'(timeout_err), 0);
    reset_n = 1'b1;
    tick();

    // Single-window conversions, cont=0
    for (int v = 0; v < 5; v++) begin
      do_start();
      check($sformatf("v%0d_busy_start", v), int'(busy), 1);
      discard4();
      strobes(vecs[v].pat, vecs[v].k, 64);
      check($sformatf("v%0d_code", v), int'(u_if.code), vecs[v].exp_code);
      check($sformatf("v%0d_valid", v), int'(u_if.code_valid), 1);
      check($sformatf("v%0d_busy_end", v), int'(busy), 0);
      accept();
      check($sformatf("v%0d_valid_acc", v), int'(u_if.code_valid), 0);
    end

    // Continuous mode, result left unconsumed then overwritten
    cont = 1'b1;
    do_start();
    discard4();
    strobes(0, 0, 64);
    check("cont_w1_code", int'(u_if.code), 0);
    check("cont_w1_valid", int'(u_if.code_valid), 1);
    check("cont_w1_overrun", int'(overrun), 0);
    strobes(1, 0, 64);
    check("cont_w2_code", int'(u_if.code), 64);
    check("cont_w2_overrun", int'(overrun), 1);
    check("cont_w2_busy", int'(busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("cont_stop_busy", int'(busy), 0);
    check("cont_stop_overrun", int'(overrun), 1);
    accept();
    check("cont_acc_valid", int'(u_if.code_valid), 0);
    cont = 1'b0;

    // Strobe gap timeout; a start pulse while busy must not restart the gap
    do_start();
    check("to_overrun_clr", int'(overrun), 0);
    discard4();
    strobes(1, 0, 6);
    for (int i = 1; i <= 254; i++) begin
      start = (i == 100);
      tick();
    end
    start = 1'b0;
    check("to_busy_254", int'(busy), 1);
    check("to_err_254", int'(timeout_err), 0);
    tick();
    check("to_err_255", int'(timeout_err), 1);
    check("to_busy_255", int'(busy), 0);
    check("to_valid", int'(u_if.code_valid), 0);

    // Completion and acceptance on the same edge
    cont = 1'b1;
    do_start();
    check("ca_timeout_clr", int'(timeout_err), 0);
    discard4();
    strobes(3, 10, 64);
    check("ca_w1_code", int'(u_if.code), 10);
    strobes(1, 0, 63);
    cmp = 1'b0; cmp_strb = 1'b1; u_if.code_ready = 1'b1;
    tick();
    cmp_strb = 1'b0; u_if.code_ready = 1'b0;
    check("ca_w2_code", int'(u_if.code), 63);
    check("ca_w2_valid", int'(u_if.code_valid), 1);
    check("ca_w2_overrun", int'(overrun), 0);

    // stop beats a simultaneous N-th strobe
    strobes(1, 0, 63);
    cmp = 1'b1; cmp_strb = 1'b1; stop = 1'b1;
    tick();
    cmp_strb = 1'b0; stop = 1'b0; cmp = 1'b0;
    check("sn_busy", int'(busy), 0);
    check("sn_code", int'(u_if.code), 63);
    check("sn_overrun", int'(overrun), 0);
    cont = 1'b0;

    // Asynchronous reset mid-ACCUM
    do_start();
    discard4();
    strobes(1, 0, 20);
    check("mid_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("ar_code", int'(u_if.code), 0);
    check("ar_valid", int'(u_if.code_valid), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_overrun", int'(overrun), 0);
    check("ar_timeout", int'(timeout_err), 0);
    tick();
    reset_n = 1'b1;
    tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", int'(busy), 0);
    tick();
    check("ss_busy2", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
